mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between two requesters: port 0 (CPU data, priority) and port 1 (display/loader).
//  The memory has a registered dataOut with 1-cycle read latency, and a write cycle produces no read data.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter_clear_sweeper.sv | 36 +++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;

endpackage

// File: rtl/mem_port_arbiter_clear_sweeper.sv
// Address sweep for the post-reset memory clear; done marks the final write cycle.
module mem_clear_sweeper #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  output logic [ADDRESS_WIDTH-1:0] count_o,
  output logic                     done_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  logic [ADDRESS_WIDTH-1:0] count_q;
  logic [ADDRESS_WIDTH-1:0] count_d;

  always_comb begin
    done_o  = en_i && (count_q == LAST_ADDR);
    count_d = count_q;
    if (en_i) begin
      count_d = done_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between a priority CPU port and a
// starvation-protected display/loader port, with an optional post-reset clear.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDRESS_WIDTH  = 12,
  parameter int                    DEPTH          = 4096,
  parameter int                    STARVE_LIMIT   = 4,
  parameter bit                    CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     busy,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam int                SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam arb_state_e        RESET_ST   = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  arb_state_e               state_q;
  logic [SW-1:0]            starve_q, starve_d;
  logic [1:0]               rvalid_q, rvalid_d;
  logic [ADDRESS_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0]    data_hold_q;

  logic                     clearing, run, force_aux, sweep_done;
  logic [1:0]               gnt;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;

  assign clearing = (state_q == ST_CLEAR) && !reset;
  assign run      = (state_q == ST_RUN) && !reset;

  mem_clear_sweeper #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH        (DEPTH)
  ) u_sweeper (
    .clk    (clk),
    .reset  (reset),
    .en_i   (clearing),
    .count_o(sweep_addr),
    .done_o (sweep_done)
  );

  always_comb begin
    force_aux     = run && req1 && (starve_q == STARVE_MAX);
    gnt[PORT_CPU] = run && req0 && !force_aux;
    gnt[PORT_AUX] = run && req1 && !gnt[PORT_CPU];

    // Idle cycles keep address/data steady so the memory sees a harmless read.
    mem_wEn    = 1'b0;
    mem_addr   = addr_hold_q;
    mem_dataIn = data_hold_q;
    if (clearing) begin
      mem_wEn    = 1'b1;
      mem_addr   = sweep_addr;
      mem_dataIn = CLEAR_VALUE;
    end else if (gnt[PORT_CPU]) begin
      mem_wEn    = we0;
      mem_addr   = addr0;
      mem_dataIn = wdata0;
    end else if (gnt[PORT_AUX]) begin
      mem_wEn    = we1;
      mem_addr   = addr1;
      mem_dataIn = wdata1;
    end

    starve_d = starve_q;
    if (!run || !req1 || gnt[PORT_AUX]) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    rvalid_d[PORT_CPU] = gnt[PORT_CPU] && !we0;
    rvalid_d[PORT_AUX] = gnt[PORT_AUX] && !we1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_ST;
      starve_q    <= '0;
      rvalid_q    <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      if (state_q == ST_CLEAR && sweep_done) begin
        state_q <= ST_RUN;
      end
      starve_q    <= starve_d;
      rvalid_q    <= rvalid_d;
      addr_hold_q <= mem_addr;
      data_hold_q <= mem_dataIn;
    end
  end

  assign gnt0    = gnt[PORT_CPU];
  assign gnt1    = gnt[PORT_AUX];
  assign rvalid0 = rvalid_q[PORT_CPU];
  assign rvalid1 = rvalid_q[PORT_AUX];
  assign rdata   = mem_dataOut;
  assign busy    = reset || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: clear sweep, directed vector table, starvation,
// reset corner cases and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 16;
  localparam int SL = 4;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_wEn;
  logic [DW-1:0] rdata, mem_dataIn, mem_dataOut;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .DEPTH         (DEPTH),
    .STARVE_LIMIT  (SL),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE   (32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .busy       (busy),
    .mem_wEn    (mem_wEn),
    .mem_addr   (mem_addr),
    .mem_dataIn (mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  // Single-port synchronous memory: registered read, writes produce no read data.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_q;
  always @(posedge clk) begin
    if (mem_wEn) mem[mem_addr] <= mem_dataIn;
    else         mem_q <= mem[mem_addr];
  end
  assign mem_dataOut = mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, v0, v1, chk;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mkv(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic r1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic g0, input logic g1, input logic v0,
                               input logic v1, input logic chk, input logic [DW-1:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.chk = chk; v.rd = rd;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    req0 = N; req1 = N; we0 = N; we1 = N;
  endtask

  vec_t          vt[$];
  logic [DW-1:0] ref_mem [0:15];
  logic          p_req [2];
  logic          p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];
  logic          exp_v0, exp_v1, eg0, eg1, prev_g0, prev_g1;
  logic [DW-1:0] exp_rd;
  int            denials;
  int            gport;

  initial begin
    reset = Y;
    drop_reqs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0 = Y; addr0 = 8'd7;

    // Reset: requests ignored, outputs quiet.
    next_cycle();
    @(negedge clk);
    check1("reset_gnt0", gnt0, N);
    check1("reset_busy", busy, Y);
    check1("reset_rvalid0", rvalid0, N);
    check1("reset_rvalid1", rvalid1, N);
    next_cycle();
    reset = N;

    // Clear sweep: exactly DEPTH writes, addresses 0..DEPTH-1, no grants.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check1($sformatf("clr_busy[%0d]", i), busy, Y);
      check1($sformatf("clr_wen[%0d]", i), mem_wEn, Y);
      check32($sformatf("clr_addr[%0d]", i), 32'(mem_addr), 32'(i));
      check1($sformatf("clr_gnt0[%0d]", i), gnt0, N);
      next_cycle();
    end
    @(negedge clk);
    check1("post_clr_busy", busy, N);
    check1("post_clr_gnt0", gnt0, Y);
    check1("post_clr_wen", mem_wEn, N);
    next_cycle();
    req0 = N;
    @(negedge clk);
    check1("clr_rd_rvalid0", rvalid0, Y);
    check32("clr_rd_data", rdata, 32'h0);
    check1("clr_rd_rvalid1", rvalid1, N);
    next_cycle();

    // Directed vectors, one row per cycle.
    vt.push_back(mkv(Y, Y, 8'd3, 32'hDEADBEEF, N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(Y, N, 8'd3, 32'h0,        N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        N, N, 8'd0, 32'h0, N, N, Y, N, Y, 32'hDEADBEEF));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        Y, Y, 8'd9, 32'h12345678, N, Y, N, N, N, 32'h0));
    vt.push_back(mkv(Y, N, 8'd9, 32'h0,        N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        N, N, 8'd0, 32'h0, N, N, Y, N, Y, 32'h12345678));
    vt.push_back(mkv(Y, Y, 8'd1, 32'hA1A1A1A1, N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(Y, Y, 8'd2, 32'hB2B2B2B2, N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(Y, Y, 8'd3, 32'hC3C3C3C3, N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(Y, N, 8'd1, 32'h0,        N, N, 8'd0, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        Y, N, 8'd2, 32'h0, N, Y, Y, N, Y, 32'hA1A1A1A1));
    vt.push_back(mkv(Y, N, 8'd3, 32'h0,        N, N, 8'd0, 32'h0, Y, N, N, Y, Y, 32'hB2B2B2B2));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        N, N, 8'd0, 32'h0, N, N, Y, N, Y, 32'hC3C3C3C3));
    vt.push_back(mkv(Y, N, 8'd5, 32'h0,        Y, N, 8'd5, 32'h0, Y, N, N, N, N, 32'h0));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        Y, N, 8'd5, 32'h0, N, Y, Y, N, Y, 32'h0));
    vt.push_back(mkv(N, N, 8'd0, 32'h0,        N, N, 8'd0, 32'h0, N, N, N, Y, Y, 32'h0));

    foreach (vt[k]) begin
      req0 = vt[k].r0; we0 = vt[k].w0; addr0 = vt[k].a0; wdata0 = vt[k].d0;
      req1 = vt[k].r1; we1 = vt[k].w1; addr1 = vt[k].a1; wdata1 = vt[k].d1;
      @(negedge clk);
      check1($sformatf("vec%0d_gnt0", k), gnt0, vt[k].g0);
      check1($sformatf("vec%0d_gnt1", k), gnt1, vt[k].g1);
      check1($sformatf("vec%0d_rvalid0", k), rvalid0, vt[k].v0);
      check1($sformatf("vec%0d_rvalid1", k), rvalid1, vt[k].v1);
      if (vt[k].chk) check32($sformatf("vec%0d_rdata", k), rdata, vt[k].rd);
      next_cycle();
    end
    drop_reqs();
    next_cycle();

    // Starvation: both ports held, port 1 forced after SL denials.
    req0 = Y; we0 = N; addr0 = 8'd1;
    req1 = Y; we1 = N; addr1 = 8'd2;
    denials = 0; prev_g0 = N; prev_g1 = N;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      eg1 = (denials == SL);
      check1($sformatf("starve%0d_gnt0", c), gnt0, !eg1);
      check1($sformatf("starve%0d_gnt1", c), gnt1, eg1);
      check1($sformatf("starve%0d_rvalid0", c), rvalid0, prev_g0);
      check1($sformatf("starve%0d_rvalid1", c), rvalid1, prev_g1);
      if (prev_g0) check32($sformatf("starve%0d_rdata", c), rdata, 32'hA1A1A1A1);
      if (prev_g1) check32($sformatf("starve%0d_rdata", c), rdata, 32'hB2B2B2B2);
      prev_g0 = !eg1; prev_g1 = eg1;
      denials = eg1 ? 0 : denials + 1;
      next_cycle();
    end
    drop_reqs();
    next_cycle();

    // Reset with a read pending: no grant, no rvalid, sweep restarts.
    req0 = Y; addr0 = 8'd1; req1 = Y; addr1 = 8'd2;
    next_cycle();
    next_cycle();
    reset = Y;
    @(negedge clk);
    check1("rst_mid_gnt0", gnt0, N);
    check1("rst_mid_gnt1", gnt1, N);
    check1("rst_mid_busy", busy, Y);
    next_cycle();
    reset = N;
    drop_reqs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check1("rst_rvalid0", rvalid0, N);
      if (i == 0) check1("rst_rvalid1", rvalid1, N);
      check32($sformatf("sweepA_addr[%0d]", i), 32'(mem_addr), 32'(i));
      next_cycle();
    end
    reset = Y;
    next_cycle();
    reset = N;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check1($sformatf("sweepB_busy[%0d]", i), busy, Y);
      check32($sformatf("sweepB_addr[%0d]", i), 32'(mem_addr), 32'(i));
      next_cycle();
    end
    req0 = Y; addr0 = 8'd1; req1 = Y; addr1 = 8'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) check1("post_rst_busy", busy, N);
      check1($sformatf("post_rst%0d_gnt1", c), gnt1, (c == 4));
      next_cycle();
    end
    drop_reqs();
    next_cycle();

    // Randomized traffic against a behavioural model.
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = N; p_we[p] = N; p_addr[p] = '0; p_data[p] = '0;
    end
    exp_v0 = N; exp_v1 = N; exp_rd = '0; denials = 0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            p_req[p]  = Y;
            p_we[p]   = ($urandom_range(0, 2) == 0);
            p_addr[p] = AW'($urandom_range(0, 15));
            p_data[p] = $urandom;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          p_req[p] = N;
        end
      end
      req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
      req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
      @(negedge clk);
      eg1 = p_req[1] && (denials == SL || !p_req[0]);
      eg0 = p_req[0] && !eg1;
      check1($sformatf("rnd%0d_gnt0", c), gnt0, eg0);
      check1($sformatf("rnd%0d_gnt1", c), gnt1, eg1);
      check1($sformatf("rnd%0d_rvalid0", c), rvalid0, exp_v0);
      check1($sformatf("rnd%0d_rvalid1", c), rvalid1, exp_v1);
      if (exp_v0 || exp_v1) check32($sformatf("rnd%0d_rdata", c), rdata, exp_rd);
      exp_v0 = N; exp_v1 = N;
      if (eg0 || eg1) begin
        gport = eg1 ? 1 : 0;
        check1($sformatf("rnd%0d_wen", c), mem_wEn, p_we[gport]);
        check32($sformatf("rnd%0d_addr", c), 32'(mem_addr), 32'(p_addr[gport]));
        if (p_we[gport]) begin
          ref_mem[p_addr[gport][3:0]] = p_data[gport];
        end else begin
          exp_rd = ref_mem[p_addr[gport][3:0]];
          if (gport == 0) exp_v0 = Y;
          else            exp_v1 = Y;
        end
        p_req[gport] = N;
      end
      denials = (p_req[1] && !eg1) ? denials + 1 : 0;
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d checks made", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule
